// File: rtl/div_wb_unit.sv
// div_wb_unit
// Iterative 32-bit signed/unsigned divider feeding the register-file write port.
// A request is latched from decode, the quotient and remainder are computed over
// 32 cycles (restoring division on operand magnitudes), and the results are
// written back on two consecutive cycles: quotient first, remainder second.
// All write-port outputs come straight from flops, so they are stable for the
// register file's falling-edge capture.
//
// Ports:
//   i_clk        clock, all state updates on the rising edge
//   i_rst        synchronous active-high reset
//   i_start      request pulse, honoured only while idle
//   i_is_signed  1 = two's-complement division, 0 = unsigned
//   i_dividend   dividend operand (latched on accept)
//   i_divisor    divisor operand (latched on accept)
//   i_q_addr     destination register for the quotient
//   i_r_addr     destination register for the remainder
//   o_busy       high in every non-idle cycle
//   o_done       one-cycle pulse on the remainder write cycle
//   o_div_zero   one-cycle pulse with o_done when the divisor was zero
//   o_we         register-file write enable
//   o_waddr      register-file write address
//   o_wdata      register-file write data
module div_wb_unit (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_is_signed,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    input  logic [4:0]  i_q_addr,
    input  logic [4:0]  i_r_addr,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_div_zero,
    output logic        o_we,
    output logic [4:0]  o_waddr,
    output logic [31:0] o_wdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_WB_Q = 2'd2,
        S_WB_R = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    // Datapath state
    logic [31:0] r_rem;        // partial remainder; holds the final remainder in WB_Q
    logic [31:0] r_quo;        // dividend magnitude shifting out, quotient bits shifting in
    logic [31:0] r_dvs_mag;
    logic [5:0]  r_cnt;
    logic [4:0]  r_q_addr;
    logic [4:0]  r_r_addr;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_div_zero;

    // Registered outputs
    logic        r_busy;
    logic        r_done;
    logic        r_dz_out;
    logic        r_we;
    logic [4:0]  r_waddr;
    logic [31:0] r_wdata;

    logic [31:0] w_dvd_mag;
    logic [31:0] w_dvs_mag;
    logic        w_dvs_zero;
    logic [32:0] w_partial;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] w_rem_step;
    logic [31:0] w_quo_step;
    logic [31:0] w_rem_fix;
    logic [31:0] w_quo_fix;
    logic        w_last;

    logic        w_we_next;
    logic [4:0]  w_waddr_next;
    logic [31:0] w_wdata_next;
    logic        w_done_next;
    logic        w_dz_next;

    // Operand magnitudes. -0x80000000 wraps to 0x80000000, which is the correct
    // unsigned magnitude, so the signed-overflow case needs no special handling.
    always_comb begin
        w_dvd_mag  = (i_is_signed && i_dividend[31]) ? (32'd0 - i_dividend) : i_dividend;
        w_dvs_mag  = (i_is_signed && i_divisor[31])  ? (32'd0 - i_divisor)  : i_divisor;
        w_dvs_zero = (i_divisor == 32'd0);
    end

    // One restoring step. The 33-bit partial remainder minus the divisor sets
    // bit 32 exactly when the subtraction would go negative: if it fits, the
    // difference is below the divisor (< 2^32); if not, it wraps to >= 2^32.
    always_comb begin
        w_partial  = {r_rem, r_quo[31]};
        w_diff     = w_partial - {1'b0, r_dvs_mag};
        w_ge       = ~w_diff[32];
        w_rem_step = w_ge ? w_diff[31:0] : w_partial[31:0];
        w_quo_step = {r_quo[30:0], w_ge};
        w_quo_fix  = r_neg_q ? (32'd0 - w_quo_step) : w_quo_step;
        w_rem_fix  = r_neg_r ? (32'd0 - w_rem_step) : w_rem_step;
        w_last     = (r_cnt == 6'd31);
    end

    // Next state and next values of the registered write port.
    always_comb begin
        w_state_next = r_state;
        w_we_next    = 1'b0;
        w_waddr_next = 5'd0;
        w_wdata_next = 32'd0;
        w_done_next  = 1'b0;
        w_dz_next    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (w_dvs_zero) begin
                        // Skip the iterations; quotient is all ones.
                        w_state_next = S_WB_Q;
                        w_we_next    = (i_q_addr != 5'd0);
                        w_waddr_next = i_q_addr;
                        w_wdata_next = 32'hFFFF_FFFF;
                    end else begin
                        w_state_next = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_state_next = S_WB_Q;
                    w_we_next    = (r_q_addr != 5'd0);
                    w_waddr_next = r_q_addr;
                    w_wdata_next = w_quo_fix;
                end
            end
            S_WB_Q: begin
                w_state_next = S_WB_R;
                w_we_next    = (r_r_addr != 5'd0);
                w_waddr_next = r_r_addr;
                w_wdata_next = r_rem;
                w_done_next  = 1'b1;
                w_dz_next    = r_div_zero;
            end
            S_WB_R: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_rem      <= 32'd0;
            r_quo      <= 32'd0;
            r_dvs_mag  <= 32'd0;
            r_cnt      <= 6'd0;
            r_q_addr   <= 5'd0;
            r_r_addr   <= 5'd0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dz_out   <= 1'b0;
            r_we       <= 1'b0;
            r_waddr    <= 5'd0;
            r_wdata    <= 32'd0;
        end else begin
            r_state  <= w_state_next;
            r_busy   <= (w_state_next != S_IDLE);
            r_done   <= w_done_next;
            r_dz_out <= w_dz_next;
            r_we     <= w_we_next;
            r_waddr  <= w_waddr_next;
            r_wdata  <= w_wdata_next;

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_dvs_mag  <= w_dvs_mag;
                        r_quo      <= w_dvd_mag;
                        r_cnt      <= 6'd0;
                        r_q_addr   <= i_q_addr;
                        r_r_addr   <= i_r_addr;
                        r_neg_q    <= i_is_signed & (i_dividend[31] ^ i_divisor[31]);
                        r_neg_r    <= i_is_signed & i_dividend[31];
                        r_div_zero <= w_dvs_zero;
                        // Divide by zero returns the raw dividend as remainder.
                        r_rem      <= w_dvs_zero ? i_dividend : 32'd0;
                    end
                end
                S_CALC: begin
                    r_quo <= w_quo_step;
                    r_cnt <= r_cnt + 6'd1;
                    // On the last step keep the sign-corrected remainder for WB_R.
                    r_rem <= w_last ? w_rem_fix : w_rem_step;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_div_zero = r_dz_out;
    assign o_we       = r_we;
    assign o_waddr    = r_waddr;
    assign o_wdata    = r_wdata;

endmodule

// File: tb/tb_div_wb_unit.sv
module tb_div_wb_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [4:0]  q_addr;
    logic [4:0]  r_addr;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    div_wb_unit dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_is_signed (is_signed),
        .i_dividend  (dividend),
        .i_divisor   (divisor),
        .i_q_addr    (q_addr),
        .i_r_addr    (r_addr),
        .o_busy      (busy),
        .o_done      (done),
        .o_div_zero  (div_zero),
        .o_we        (we),
        .o_waddr     (waddr),
        .o_wdata     (wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic [4:0]  qa;
        logic [4:0]  ra;
        logic [31:0] eq;
        logic [31:0] er;
        int          glitch;   // cycle at which to pulse a stray start, -1 = none
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        done;
        logic        dz;
    } wr_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];
    wr_t  sb_q [$];

    int checks = 0;
    int errors = 0;

    // Register-file model capturing on the falling edge.
    logic [31:0] rf [32];
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else if (we) begin
            rf[waddr] <= wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference division using the language's own operators.
    task automatic ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
        int sa;
        int sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else begin
                sa = a;
                sb = b;
                q = sa / sb;
                r = sa % sb;
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    task automatic set_vec(input int i, input logic sgn, input logic [31:0] dvd,
                           input logic [31:0] dvs, input logic [4:0] qa, input logic [4:0] ra,
                           input logic [31:0] eq, input logic [31:0] er, input int glitch);
        vecs[i].sgn = sgn;   vecs[i].dvd = dvd; vecs[i].dvs = dvs;
        vecs[i].qa  = qa;    vecs[i].ra  = ra;
        vecs[i].eq  = eq;    vecs[i].er  = er;  vecs[i].glitch = glitch;
    endtask

    // Drive one request, then walk it cycle by cycle against the scoreboard.
    task automatic run_op(input int idx);
        vec_t v;
        wr_t  e;
        wr_t  tmp;
        int   lat;
        logic quiet_ok;
        v = vecs[idx];

        tmp.we = (v.qa != 5'd0); tmp.addr = v.qa; tmp.data = v.eq; tmp.done = 1'b0; tmp.dz = 1'b0;
        sb_q.push_back(tmp);
        tmp.we = (v.ra != 5'd0); tmp.addr = v.ra; tmp.data = v.er; tmp.done = 1'b1; tmp.dz = (v.dvs == 32'd0);
        sb_q.push_back(tmp);

        is_signed = v.sgn; dividend = v.dvd; divisor = v.dvs; q_addr = v.qa; r_addr = v.ra;
        start = 1'b1;
        step();                                   // now in cycle 1
        start = 1'b0;
        dividend = $urandom; divisor = $urandom; q_addr = 5'd31; r_addr = 5'd30;
        lat = (v.dvs == 32'd0) ? 1 : 33;

        quiet_ok = 1'b1;
        for (int cyc = 1; cyc < lat; cyc++) begin
            if (!busy || we || done || div_zero) quiet_ok = 1'b0;
            if (cyc == v.glitch) begin
                start = 1'b1; is_signed = 1'b0; dividend = 32'd1; divisor = 32'd1;
                q_addr = 5'd1; r_addr = 5'd2;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        chk("calc_quiet", {31'd0, quiet_ok}, 32'd1);

        // Quotient write cycle
        if (sb_q.size() == 0) begin
            chk("sb_empty_q", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk("q_we", {31'd0, we}, {31'd0, e.we});
            chk("q_waddr", {27'd0, waddr}, {27'd0, e.addr});
            chk("q_wdata", wdata, e.data);
            chk("q_done", {31'd0, done}, {31'd0, e.done});
            chk("q_busy", {31'd0, busy}, 32'd1);
        end
        step();

        // Remainder write cycle
        if (sb_q.size() == 0) begin
            chk("sb_empty_r", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk("r_we", {31'd0, we}, {31'd0, e.we});
            chk("r_waddr", {27'd0, waddr}, {27'd0, e.addr});
            chk("r_wdata", wdata, e.data);
            chk("r_done", {31'd0, done}, {31'd0, e.done});
            chk("r_div_zero", {31'd0, div_zero}, {31'd0, e.dz});
        end
        step();

        // Back to idle
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_we", {31'd0, we}, 32'd0);
        chk("idle_done", {31'd0, done}, 32'd0);
        if (v.ra != 5'd0) chk("rf_rem", rf[v.ra], v.er);
        if (v.qa != 5'd0 && v.qa != v.ra) chk("rf_quo", rf[v.qa], v.eq);
        chk("rf_zero", rf[0], 32'd0);
        $display("op %0d: %s %h / %h -> q=%h r=%h (qa=%0d ra=%0d)", idx,
                 v.sgn ? "s" : "u", v.dvd, v.dvs, v.eq, v.er, v.qa, v.ra);
    endtask

    initial begin
        logic [31:0] mq;
        logic [31:0] mr;
        logic        saw_we;
        int          qa;

        rst = 1'b1; start = 1'b0; is_signed = 1'b0;
        dividend = 32'd0; divisor = 32'd0; q_addr = 5'd0; r_addr = 5'd0;

        set_vec(0,  1'b0, 32'd100,        32'd7,          5'd8, 5'd9, 32'd14,        32'd2,         -1);
        set_vec(1,  1'b1, 32'hFFFF_FFF9,  32'd2,          5'd1, 5'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, -1);
        set_vec(2,  1'b0, 32'hFFFF_FFF9,  32'd2,          5'd3, 5'd4, 32'h7FFF_FFFC, 32'd1,         -1);
        set_vec(3,  1'b0, 32'h1234_5678,  32'd0,          5'd3, 5'd4, 32'hFFFF_FFFF, 32'h1234_5678, -1);
        set_vec(4,  1'b1, 32'h8765_4321,  32'd0,          5'd6, 5'd7, 32'hFFFF_FFFF, 32'h8765_4321, -1);
        set_vec(5,  1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  5'd10,5'd11,32'h8000_0000, 32'd0,         -1);
        set_vec(6,  1'b0, 32'd100,        32'd7,          5'd0, 5'd5, 32'd14,        32'd2,         -1);
        set_vec(7,  1'b0, 32'd100,        32'd7,          5'd5, 5'd5, 32'd14,        32'd2,         -1);
        set_vec(8,  1'b0, 32'd100,        32'd7,          5'd8, 5'd9, 32'd14,        32'd2,         10);
        set_vec(9,  1'b1, 32'd7,          32'hFFFF_FFFE,  5'd12,5'd13,32'hFFFF_FFFD, 32'd1,         -1);
        set_vec(10, 1'b1, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  5'd14,5'd15,32'd2,         32'hFFFF_FFFE, -1);
        set_vec(11, 1'b0, 32'hFFFF_FFFF,  32'd1,          5'd16,5'd17,32'hFFFF_FFFF, 32'd0,         -1);
        for (int i = 12; i < NVEC; i++) begin
            vecs[i].sgn = 1'($urandom_range(0, 1));
            vecs[i].dvd = $urandom;
            vecs[i].dvs = $urandom >> $urandom_range(0, 28);
            qa = $urandom_range(1, 31);
            vecs[i].qa = 5'(qa);
            vecs[i].ra = 5'((qa % 31) + 1);
            vecs[i].glitch = -1;
            ref_div(vecs[i].sgn, vecs[i].dvd, vecs[i].dvs, mq, mr);
            vecs[i].eq = mq;
            vecs[i].er = mr;
        end

        // Reset state
        repeat (3) step();
        rst = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_div_zero", {31'd0, div_zero}, 32'd0);
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_waddr", {27'd0, waddr}, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        step();

        for (int i = 0; i < NVEC; i++) begin
            run_op(i);
            step();
        end

        // Reset in the middle of a calculation (cycle 20)
        is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; q_addr = 5'd8; r_addr = 5'd9;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 1; cyc < 20; cyc++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_div_zero", {31'd0, div_zero}, 32'd0);
        chk("midrst_we", {31'd0, we}, 32'd0);
        chk("midrst_waddr", {27'd0, waddr}, 32'd0);
        chk("midrst_wdata", wdata, 32'd0);
        saw_we = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (we || busy) saw_we = 1'b1;
            step();
        end
        chk("midrst_no_write", {31'd0, saw_we}, 32'd0);
        $display("op rst: reset at cycle 20, no write-back afterwards");

        // Recovery after the aborted operation
        run_op(0);

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
